// File: rtl/branch_rs_pkg.sv
// Shared opcode encodings and default widths for the branch reservation station.
package branch_rs_pkg;
    localparam int TAG_W_DEF = 4;

    typedef enum logic [3:0] {
        OP_BEQ  = 4'd0,
        OP_BNE  = 4'd1,
        OP_BLT  = 4'd2,
        OP_BGE  = 4'd3,
        OP_BLTU = 4'd4,
        OP_BGEU = 4'd5,
        OP_JAL  = 4'd6,
        OP_JALR = 4'd7
    } br_op_e;
endpackage

// File: rtl/branch_rs_alu.sv
// Combinational branch/jump resolution: condition, target and link value.
module branch_alu
    import branch_rs_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [31:0] vj,
    input  logic [31:0] vk,
    output logic        taken,
    output logic        is_jump,
    output logic [31:0] target,
    output logic [31:0] link
);
    logic [31:0] pc_imm;
    logic [31:0] jalr_sum;
    logic [31:0] pc_4;
    logic        is_br;
    logic        cond;

    always_comb begin
        pc_imm   = pc + imm;
        jalr_sum = vj + imm;
        pc_4     = pc + 32'd4;
        is_br    = 1'b0;
        cond     = 1'b0;
        taken    = 1'b0;
        is_jump  = 1'b0;
        target   = '0;
        link     = '0;
        case (op)
            OP_BEQ:  begin is_br = 1'b1; cond = (vj == vk); end
            OP_BNE:  begin is_br = 1'b1; cond = (vj != vk); end
            OP_BLT:  begin is_br = 1'b1; cond = ($signed(vj) <  $signed(vk)); end
            OP_BGE:  begin is_br = 1'b1; cond = ($signed(vj) >= $signed(vk)); end
            OP_BLTU: begin is_br = 1'b1; cond = (vj <  vk); end
            OP_BGEU: begin is_br = 1'b1; cond = (vj >= vk); end
            OP_JAL: begin
                taken   = 1'b1;
                is_jump = 1'b1;
                target  = pc_imm;
                link    = pc_4;
            end
            OP_JALR: begin
                taken   = 1'b1;
                is_jump = 1'b1;
                target  = {jalr_sum[31:1], 1'b0};
                link    = pc_4;
            end
            default: ;
        endcase
        // Not-taken branches report a zero target.
        if (is_br && cond) begin
            taken  = 1'b1;
            target = pc_imm;
        end
    end
endmodule

// File: rtl/branch_rs.sv
// Reservation station for control-flow ops: dispatch, CDB wakeup, in-order-by-index issue.
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int RS_DEPTH = 8,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int NUM_CDB  = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [3:0]               in_op,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_imm,
    input  logic                     in_qj_busy,
    input  logic                     in_qk_busy,
    input  logic [TAG_W-1:0]         in_qj,
    input  logic [TAG_W-1:0]         in_qk,
    input  logic [31:0]              in_vj,
    input  logic [31:0]              in_vk,
    output logic                     full,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
    input  logic [NUM_CDB*32-1:0]    cdb_value,
    output logic                     out_valid,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_is_jump,
    output logic                     out_taken,
    output logic [31:0]              out_target,
    output logic [31:0]              out_link
);
    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [RS_DEPTH-1:0] valid, qj_busy, qk_busy;
    logic [3:0]          op  [RS_DEPTH];
    logic [31:0]         pc  [RS_DEPTH];
    logic [31:0]         imm [RS_DEPTH];
    logic [31:0]         vj  [RS_DEPTH];
    logic [31:0]         vk  [RS_DEPTH];
    logic [TAG_W-1:0]    tag [RS_DEPTH];
    logic [TAG_W-1:0]    qj  [RS_DEPTH];
    logic [TAG_W-1:0]    qk  [RS_DEPTH];

    logic [RS_DEPTH-1:0] j_wake, k_wake;
    logic [31:0]         j_val [RS_DEPTH];
    logic [31:0]         k_val [RS_DEPTH];
    logic                in_j_hit, in_k_hit;
    logic [31:0]         in_j_val, in_k_val;
    logic                alloc, issue_ok;
    logic [IDX_W-1:0]    alloc_idx, issue_idx;

    // CDB match: channels scanned high to low so the lowest matching channel wins.
    always_comb begin
        in_j_hit = 1'b0; in_k_hit = 1'b0;
        in_j_val = '0;   in_k_val = '0;
        j_wake   = '0;   k_wake   = '0;
        for (int e = 0; e < RS_DEPTH; e++) begin
            j_val[e] = '0;
            k_val[e] = '0;
        end
        for (int c = NUM_CDB-1; c >= 0; c--) begin
            if (cdb_valid[c]) begin
                if (cdb_tag[c*TAG_W +: TAG_W] == in_qj) begin
                    in_j_hit = 1'b1; in_j_val = cdb_value[c*32 +: 32];
                end
                if (cdb_tag[c*TAG_W +: TAG_W] == in_qk) begin
                    in_k_hit = 1'b1; in_k_val = cdb_value[c*32 +: 32];
                end
                for (int e = 0; e < RS_DEPTH; e++) begin
                    if (valid[e] && qj_busy[e] && cdb_tag[c*TAG_W +: TAG_W] == qj[e]) begin
                        j_wake[e] = 1'b1; j_val[e] = cdb_value[c*32 +: 32];
                    end
                    if (valid[e] && qk_busy[e] && cdb_tag[c*TAG_W +: TAG_W] == qk[e]) begin
                        k_wake[e] = 1'b1; k_val[e] = cdb_value[c*32 +: 32];
                    end
                end
            end
        end
    end

    always_comb begin
        alloc_idx = '0;
        issue_idx = '0;
        issue_ok  = 1'b0;
        for (int e = RS_DEPTH-1; e >= 0; e--) begin
            if (!valid[e]) alloc_idx = IDX_W'(e);
            if (valid[e] && !qj_busy[e] && !qk_busy[e]) begin
                issue_ok  = 1'b1;
                issue_idx = IDX_W'(e);
            end
        end
    end

    assign full  = &valid;
    assign alloc = in_valid && !full && !flush;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid   <= '0;
            qj_busy <= '0;
            qk_busy <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                valid <= '0;
            end else begin
                for (int e = 0; e < RS_DEPTH; e++) begin
                    if (j_wake[e]) qj_busy[e] <= 1'b0;
                    if (k_wake[e]) qk_busy[e] <= 1'b0;
                end
                if (issue_ok) valid[issue_idx] <= 1'b0;
                if (alloc) begin
                    valid[alloc_idx]   <= 1'b1;
                    qj_busy[alloc_idx] <= in_qj_busy && !in_j_hit;
                    qk_busy[alloc_idx] <= in_qk_busy && !in_k_hit;
                end
            end
        end
    end

    // Payload needs no reset: it is only read while the matching valid bit is set.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                if (j_wake[e]) vj[e] <= j_val[e];
                if (k_wake[e]) vk[e] <= k_val[e];
            end
            if (alloc) begin
                op[alloc_idx]  <= in_op;
                pc[alloc_idx]  <= in_pc;
                imm[alloc_idx] <= in_imm;
                tag[alloc_idx] <= in_tag;
                qj[alloc_idx]  <= in_qj;
                qk[alloc_idx]  <= in_qk;
                vj[alloc_idx]  <= (in_qj_busy && in_j_hit) ? in_j_val : in_vj;
                vk[alloc_idx]  <= (in_qk_busy && in_k_hit) ? in_k_val : in_vk;
            end
        end
    end

    logic        alu_taken, alu_jump;
    logic [31:0] alu_target, alu_link;

    branch_alu u_alu (
        .op      (op[issue_idx]),
        .pc      (pc[issue_idx]),
        .imm     (imm[issue_idx]),
        .vj      (vj[issue_idx]),
        .vk      (vk[issue_idx]),
        .taken   (alu_taken),
        .is_jump (alu_jump),
        .target  (alu_target),
        .link    (alu_link)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid   <= 1'b0;
            out_tag     <= '0;
            out_is_jump <= 1'b0;
            out_taken   <= 1'b0;
            out_target  <= '0;
            out_link    <= '0;
        end else if (rdy_in) begin
            out_valid <= issue_ok && !flush;
            if (issue_ok && !flush) begin
                out_tag     <= tag[issue_idx];
                out_is_jump <= alu_jump;
                out_taken   <= alu_taken;
                out_target  <= alu_target;
                out_link    <= alu_link;
            end
        end
    end
endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: opcode vector table plus wakeup/full/flush/enable sequences.
module tb_branch_rs;
    import branch_rs_pkg::*;
    localparam int RS_DEPTH = 8;
    localparam int TAG_W    = 4;
    localparam int NUM_CDB  = 2;
    localparam int NVEC     = 11;

    logic                     clk_in = 1'b0;
    logic                     rst_in, rdy_in, flush, in_valid;
    logic [TAG_W-1:0]         in_tag, in_qj, in_qk;
    logic [3:0]               in_op;
    logic [31:0]              in_pc, in_imm, in_vj, in_vk;
    logic                     in_qj_busy, in_qk_busy;
    logic                     full;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*32-1:0]    cdb_value;
    logic                     out_valid, out_is_jump, out_taken;
    logic [TAG_W-1:0]         out_tag;
    logic [31:0]              out_target, out_link;

    int n_chk  = 0;
    int n_fail = 0;

    branch_rs #(.RS_DEPTH(RS_DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
        .in_valid(in_valid), .in_tag(in_tag), .in_op(in_op), .in_pc(in_pc),
        .in_imm(in_imm), .in_qj_busy(in_qj_busy), .in_qk_busy(in_qk_busy),
        .in_qj(in_qj), .in_qk(in_qk), .in_vj(in_vj), .in_vk(in_vk), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .out_valid(out_valid), .out_tag(out_tag), .out_is_jump(out_is_jump),
        .out_taken(out_taken), .out_target(out_target), .out_link(out_link)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pc, imm, vj, vk;
        logic        taken, jump;
        logic [31:0] target, link;
    } vec_t;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; cdb_valid = '0;
        in_qj_busy = 1'b0; in_qk_busy = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [TAG_W-1:0] tg,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] vj, input logic [31:0] vk,
                        input logic jb, input logic [TAG_W-1:0] qj);
        in_valid = 1'b1; in_op = op; in_tag = tg; in_pc = pc; in_imm = imm;
        in_vj = vj; in_vk = vk; in_qj_busy = jb; in_qj = qj;
        in_qk_busy = 1'b0; in_qk = '0;
    endtask

    initial begin
        vecs[0]  = '{OP_BEQ,  32'h100,      32'h20,       32'd5,        32'd5,        1'b1, 1'b0, 32'h120,  32'h0};
        vecs[1]  = '{OP_BNE,  32'h100,      32'h20,       32'd5,        32'd5,        1'b0, 1'b0, 32'h0,    32'h0};
        vecs[2]  = '{OP_BLT,  32'h200,      32'h10,       32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 32'h210,  32'h0};
        vecs[3]  = '{OP_BLTU, 32'h200,      32'h10,       32'hFFFFFFFF, 32'd1,        1'b0, 1'b0, 32'h0,    32'h0};
        vecs[4]  = '{OP_BGE,  32'h300,      32'hFFFFFFF0, 32'd1,        32'hFFFFFFFF, 1'b1, 1'b0, 32'h2F0,  32'h0};
        vecs[5]  = '{OP_BGEU, 32'h300,      32'hFFFFFFF0, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,    32'h0};
        vecs[6]  = '{OP_JAL,  32'h400,      32'h100,      32'h0,        32'h0,        1'b1, 1'b1, 32'h500,  32'h404};
        vecs[7]  = '{OP_JALR, 32'h80,       32'h2,        32'h1001,     32'h0,        1'b1, 1'b1, 32'h1002, 32'h84};
        vecs[8]  = '{4'd8,    32'h900,      32'h40,       32'd3,        32'd3,        1'b0, 1'b0, 32'h0,    32'h0};
        vecs[9]  = '{OP_BEQ,  32'hFFFFFFF0, 32'h20,       32'h0,        32'h0,        1'b1, 1'b0, 32'h10,   32'h0};
        vecs[10] = '{OP_BGE,  32'h10,       32'h8,        32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h18,   32'h0};

        rst_in = 1'b1; rdy_in = 1'b1;
        in_tag = '0; in_op = '0; in_pc = '0; in_imm = '0; in_vj = '0; in_vk = '0;
        in_qj = '0; in_qk = '0; cdb_tag = '0; cdb_value = '0;
        idle();
        step(); step();
        rst_in = 1'b0;
        chk("rst_full", full, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_is_jump", out_is_jump, 0);
        chk("rst_out_taken", out_taken, 0);
        chk("rst_out_target", out_target, 0);
        chk("rst_out_link", out_link, 0);

        for (int i = 0; i < NVEC; i++) begin
            disp(vecs[i].op, TAG_W'(i), vecs[i].pc, vecs[i].imm, vecs[i].vj, vecs[i].vk, 1'b0, '0);
            step(); idle();
            chk($sformatf("v%0d_not_yet", i), out_valid, 0);
            step();
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_tag", i), out_tag, i);
            chk($sformatf("v%0d_taken", i), out_taken, vecs[i].taken);
            chk($sformatf("v%0d_jump", i), out_is_jump, vecs[i].jump);
            chk($sformatf("v%0d_target", i), out_target, vecs[i].target);
            chk($sformatf("v%0d_link", i), out_link, vecs[i].link);
            step();
            chk($sformatf("v%0d_pulse", i), out_valid, 0);
            chk($sformatf("v%0d_hold", i), out_target, vecs[i].target);
        end

        // JALR waits on tag 7, woken by CDB channel 1
        disp(OP_JALR, 4'd4, 32'h40, 32'h4, 32'hDEAD, 32'h0, 1'b1, 4'd7);
        step(); idle();
        cdb_valid = 2'b10; cdb_tag = {4'd7, 4'd0}; cdb_value = {32'h1003, 32'h0};
        chk("jalr_wait0", out_valid, 0);
        step(); idle();
        chk("jalr_wait1", out_valid, 0);
        step();
        chk("jalr_valid", out_valid, 1);
        chk("jalr_tag", out_tag, 4);
        chk("jalr_target", out_target, 32'h1006);
        chk("jalr_link", out_link, 32'h44);
        chk("jalr_taken", out_taken, 1);
        chk("jalr_jump", out_is_jump, 1);
        step();

        // same-cycle bypass from CDB channel 0 during dispatch
        disp(OP_BEQ, 4'd6, 32'h20, 32'h8, 32'h0, 32'd9, 1'b1, 4'd2);
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd2}; cdb_value = {32'h0, 32'd9};
        step(); idle();
        step();
        chk("byp_valid", out_valid, 1);
        chk("byp_tag", out_tag, 6);
        chk("byp_taken", out_taken, 1);
        chk("byp_target", out_target, 32'h28);
        step();

        // fill all entries waiting on tags 8..15
        for (int i = 0; i < RS_DEPTH; i++) begin
            disp(OP_BEQ, TAG_W'(i), 32'h1000 + 32'(i*4), 32'h10, 32'h0, 32'h0, 1'b1, TAG_W'(8 + i));
            step();
            chk($sformatf("fill%0d_full", i), full, (i == RS_DEPTH-1));
        end
        disp(OP_BEQ, 4'd15, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, '0);
        step(); idle();
        chk("drop_full", full, 1);
        chk("drop_out0", out_valid, 0);
        step();
        chk("drop_out1", out_valid, 0);
        cdb_valid = 2'b11; cdb_tag = {4'd9, 4'd13}; cdb_value = '0;
        step(); idle();
        chk("wake_out", out_valid, 0);
        chk("wake_full", full, 1);
        step();
        chk("iss1_valid", out_valid, 1);
        chk("iss1_tag", out_tag, 1);
        chk("iss1_target", out_target, 32'h1014);
        chk("iss1_full", full, 0);
        step();
        chk("iss5_valid", out_valid, 1);
        chk("iss5_tag", out_tag, 5);
        chk("iss5_target", out_target, 32'h1024);
        step();
        chk("iss_done", out_valid, 0);
        flush = 1'b1;
        step(); idle();
        chk("clr_full", full, 0);

        // flush beats allocation and wakeup in the same cycle
        for (int i = 0; i < 3; i++) begin
            disp(OP_BEQ, TAG_W'(i), 32'h2000, 32'h10, 32'h0, 32'h0, 1'b1, TAG_W'(8 + i));
            step();
        end
        disp(OP_BEQ, 4'd3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, '0);
        flush = 1'b1;
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd8}; cdb_value = '0;
        step(); idle();
        chk("fl_full", full, 0);
        chk("fl_out0", out_valid, 0);
        step();
        chk("fl_out1", out_valid, 0);
        cdb_valid = 2'b11; cdb_tag = {4'd10, 4'd9}; cdb_value = '0;
        step(); idle();
        chk("fl_out2", out_valid, 0);
        step();
        chk("fl_out3", out_valid, 0);
        disp(OP_JAL, 4'd11, 32'h600, 32'h40, 32'h0, 32'h0, 1'b0, '0);
        step(); idle();
        step();
        chk("postfl_valid", out_valid, 1);
        chk("postfl_tag", out_tag, 11);
        chk("postfl_target", out_target, 32'h640);
        chk("postfl_link", out_link, 32'h604);
        step();

        // rdy_in low ignores dispatch and freezes state and outputs
        rdy_in = 1'b0;
        disp(OP_BNE, 4'd12, 32'h700, 32'h8, 32'd1, 32'd2, 1'b0, '0);
        step(); idle();
        step();
        chk("rdy_ign0", out_valid, 0);
        rdy_in = 1'b1;
        step();
        chk("rdy_ign1", out_valid, 0);
        disp(OP_BNE, 4'd12, 32'h700, 32'h8, 32'd1, 32'd2, 1'b0, '0);
        step(); idle();
        rdy_in = 1'b0;
        step();
        chk("frz_valid0", out_valid, 0);
        step();
        chk("frz_valid1", out_valid, 0);
        chk("frz_tag_hold", out_tag, 11);
        rdy_in = 1'b1;
        step();
        chk("rdy_valid", out_valid, 1);
        chk("rdy_tag", out_tag, 12);
        chk("rdy_taken", out_taken, 1);
        chk("rdy_target", out_target, 32'h708);
        rdy_in = 1'b0;
        step();
        chk("frz_pulse", out_valid, 1);
        rdy_in = 1'b1;
        step();
        chk("unfrz_pulse", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_rs.md
Name: branch_rs

Overview:
- Parametrised reservation station and execute unit for RISC-V control-flow instructions (BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR) in the Tomasulo core.
- Accepts dispatched entries from decode/ROB and snoops NUM_CDB result buses for operand wakeup.
- Issues one ready entry per cycle and produces a registered branch outcome (taken, target, link value) for the ROB.
- Supports flush on misprediction and exposes a full flag for dispatch back-pressure.

Parameters:
- RS_DEPTH, 8, number of entries (>=2).
- TAG_W, 4, ROB tag width.
- NUM_CDB, 2, number of snooped CDB channels.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  asynchronous active-high reset.
- rdy_in  in  1  global enable; low freezes all state and outputs.
- flush  in  1  invalidate all entries.
- in_valid  in  1  dispatch request.
- in_tag  in  TAG_W  destination ROB tag.
- in_op  in  4  opcode code from shared package.
- in_pc  in  32  instruction address.
- in_imm  in  32  sign-extended immediate.
- in_qj_busy, in_qk_busy  in  1 each  operand still pending.
- in_qj, in_qk  in  TAG_W each  producer tags.
- in_vj, in_vk  in  32 each  operand values when not busy.
- full  out  1  no free entry.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_tag  in  NUM_CDB*TAG_W  packed tags, channel c at [c*TAG_W +: TAG_W].
- cdb_value  in  NUM_CDB*32  packed values.
- out_valid  out  1  result pulse.
- out_tag  out  TAG_W  ROB tag of result.
- out_is_jump  out  1  1 for JAL/JALR, 0 for conditional branch.
- out_taken  out  1  control transfer taken.
- out_target  out  32  target address; 0 when not taken.
- out_link  out  32  pc+4 for jumps, 0 for branches.

Behaviour:
- Reset (async): all entries invalid; full=0; out_valid, out_tag, out_is_jump, out_taken, out_target, out_link all 0.
- rdy_in=0: nothing changes, including outputs; dispatch and CDB inputs are ignored.
- Entry state: valid, op, pc, imm, tag, qj_busy/qj/vj, qk_busy/qk/vk.
- full: combinational; 1 iff all RS_DEPTH entries are valid at start of cycle. Entries freed in the same cycle do not lower full until the next cycle.
- Allocation: if in_valid && !full && !flush, write the lowest-index invalid entry at the edge.
- Same-cycle CDB bypass on allocation: if in_qj_busy and any cdb_valid[c] has a matching tag, store the value and mark the operand ready; same for k.
- JAL ignores both operands. JALR ignores k. Decode drives the ignored busy bits to 0.
- Wakeup: each valid busy operand compares against all NUM_CDB channels every cycle. On a match it captures the value and clears busy. If multiple channels match, the lowest channel wins (tags are unique, so this is defensive only).
- Issue: each cycle, select the lowest-index valid entry whose operands are both non-busy in registered state. Register its result and invalidate the entry at the same edge.
- Issue latency: an entry allocated ready at edge E, or woken at edge E, can appear on out_* at edge E+1 at the earliest.
- out_valid is a 1-cycle pulse. When no entry issues, out_valid=0 and the other outputs hold their previous values.
- Branch compare: BLT/BGE are signed; BLTU/BGEU are unsigned. Taken branch target = pc+imm, mod 2^32.
- JAL: taken=1, target = pc+imm, link = pc+4.
- JALR: taken=1, target = (vj+imm) & ~1, link = pc+4.
- Undefined opcode: issued with taken=0, is_jump=0, target=0.
- flush=1 (while rdy_in=1): all entries invalid and out_valid=0 at the edge. Flush has priority over allocation, wakeup and issue in the same cycle.

Decomposition:
- Shared define file holds opcode codes BEQ=0, BNE=1, BLT=2, BGE=3, BLTU=4, BGEU=5, JAL=6, JALR=7, and the default TAG_W.
- One combinational sub-module, branch_alu: takes op, pc, imm, vj, vk and returns taken, is_jump, target, link.
- Selection and wakeup logic stay in branch_rs.

Test Plan:
- Reset, then dispatch BEQ with vj=vk=5, pc=0x100, imm=0x20, tag=3 -> one cycle later out_valid=1, tag=3, taken=1, target=0x120, is_jump=0.
- BLT with vj=0xFFFFFFFF, vk=1 -> taken=1. BLTU with the same operands -> taken=0, target=0.
- JALR with qj busy on tag 7; CDB channel 1 broadcasts tag 7, value 0x1003; imm=4, pc=0x40 -> next cycle target=0x1006, link=0x44, taken=1, is_jump=1.
- Dispatch with in_qj_busy=1, tag 2, while cdb channel 0 carries tag 2, value 9 in the same cycle -> the entry is ready and issues at the next edge.
- Fill RS_DEPTH entries all waiting -> full=1, and a further in_valid is dropped. Wake entries 5 and 1 together -> entry 1 issues first, then entry 5.
- Fill 3 entries, assert flush alongside in_valid and a matching CDB broadcast -> all entries invalid, full=0, no out_valid; a later ready dispatch issues normally.
